// File: rtl/ysyx_220066_mem_pkg.sv
// rtl/ysyx_220066_mem_pkg.sv - shared constants, state encoding and address helpers for the line bridge
package ysyx_220066_mem_pkg;

    localparam int LINE_LEN = 512;
    localparam int BEAT_W   = 64;
    localparam int BEATS    = LINE_LEN / BEAT_W;
    localparam int ADDR_W   = 32;
    localparam int IDX_W    = $clog2(BEATS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_t;

    function automatic logic is_uncached(input logic [ADDR_W-1:0] a);
        return ~a[ADDR_W-1];
    endfunction

    // Uncached requests keep their byte address; cached beats walk the 64B line.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                    input logic              unc,
                                                    input logic [IDX_W-1:0]  idx);
        return unc ? base : {base[ADDR_W-1:6], idx, 3'b000};
    endfunction

endpackage

// File: rtl/ysyx_220066_line_buf.sv
// rtl/ysyx_220066_line_buf.sv - line register with beat write port, whole-line load/clear and beat read mux
module ysyx_220066_line_buf
    import ysyx_220066_mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                load,
    input  logic [LINE_LEN-1:0] load_data,
    input  logic                beat_we,
    input  logic [IDX_W-1:0]    beat_idx,
    input  logic [BEAT_W-1:0]   beat_wdata,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [BEAT_W-1:0]   rd_beat,
    output logic [LINE_LEN-1:0] line
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line <= '0;
        end else if (clear) begin
            line <= '0;
        end else if (load) begin
            line <= load_data;
        end else if (beat_we) begin
            line[beat_idx*BEAT_W +: BEAT_W] <= beat_wdata;
        end
    end

    assign rd_beat = line[rd_idx*BEAT_W +: BEAT_W];

endmodule

// File: rtl/ysyx_220066_line_bridge.sv
// rtl/ysyx_220066_line_bridge.sv - serialises cache line refill/writeback into single-beat memory transactions
module ysyx_220066_line_bridge
    import ysyx_220066_mem_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                rd_req,
    output logic                rd_ready,
    output logic [LINE_LEN-1:0] rd_data,
    output logic                rd_error,
    input  logic                wr_req,
    input  logic [LINE_LEN-1:0] wr_data,
    output logic                wr_ready,
    output logic                wr_error,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [BEAT_W-1:0]   mem_wdata,
    output logic [7:0]          mem_wstrb,
    input  logic [BEAT_W-1:0]   mem_rdata,
    input  logic                mem_err
);

    state_t             state;
    logic [IDX_W-1:0]   count;
    logic [IDX_W-1:0]   count_nxt;
    logic [ADDR_W-1:0]  addr_q;
    logic               uncached_q;
    logic               err_acc;
    logic               last_beat;
    logic               buf_clear;
    logic               buf_load;
    logic               buf_beat_we;
    logic [BEAT_W-1:0]  buf_rd_beat;

    assign count_nxt   = count + IDX_W'(1);
    assign last_beat   = uncached_q || (count == IDX_W'(BEATS - 1));
    assign buf_load    = (state == ST_IDLE) && wr_req;
    assign buf_clear   = (state == ST_IDLE) && !wr_req && rd_req;
    assign buf_beat_we = (state == ST_RD) && mem_ready;

    assign mem_wstrb = 8'hFF;
    assign rd_error  = rd_ready & err_acc;
    assign wr_error  = wr_ready & err_acc;

    // Read port looks one beat ahead so the next mem_wdata is ready when a beat completes.
    ysyx_220066_line_buf u_line_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (buf_clear),
        .load       (buf_load),
        .load_data  (wr_data),
        .beat_we    (buf_beat_we),
        .beat_idx   (count),
        .beat_wdata (mem_rdata),
        .rd_idx     (count_nxt),
        .rd_beat    (buf_rd_beat),
        .line       (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            addr_q     <= '0;
            uncached_q <= 1'b0;
            err_acc    <= 1'b0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rd_ready   <= 1'b0;
            wr_ready   <= 1'b0;
        end else begin
            rd_ready <= 1'b0;
            wr_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_req || rd_req) begin
                        addr_q     <= addr;
                        uncached_q <= is_uncached(addr);
                        count      <= '0;
                        err_acc    <= 1'b0;
                        mem_valid  <= 1'b1;
                        mem_addr   <= beat_addr(addr, is_uncached(addr), '0);
                        mem_we     <= wr_req;
                        mem_wdata  <= wr_req ? wr_data[BEAT_W-1:0] : '0;
                        state      <= wr_req ? ST_WR : ST_RD;
                    end
                end
                ST_RD, ST_WR: begin
                    if (mem_ready) begin
                        err_acc <= err_acc | mem_err;
                        if (last_beat) begin
                            mem_valid <= 1'b0;
                            mem_we    <= 1'b0;
                            count     <= '0;
                            rd_ready  <= (state == ST_RD);
                            wr_ready  <= (state == ST_WR);
                            state     <= ST_DONE;
                        end else begin
                            count     <= count_nxt;
                            mem_addr  <= beat_addr(addr_q, uncached_q, count_nxt);
                            mem_wdata <= buf_rd_beat;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_220066_line_bridge.sv
// tb/tb_ysyx_220066_line_bridge.sv - directed self-checking bench for the line bridge
module tb_ysyx_220066_line_bridge;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  addr = '0;
    logic         rd_req = 1'b0;
    logic         rd_ready;
    logic [511:0] rd_data;
    logic         rd_error;
    logic         wr_req = 1'b0;
    logic [511:0] wr_data = '0;
    logic         wr_ready;
    logic         wr_error;
    logic         mem_valid;
    logic         mem_ready = 1'b0;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic [7:0]   mem_wstrb;
    logic [63:0]  mem_rdata = '0;
    logic         mem_err = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0]  addr_log [16];
    logic [63:0]  wdata_log [16];
    logic         we_log [16];
    logic [63:0]  rdata_tab [8];
    int           beats, rdy_cyc, rd_pulses, wr_pulses, hold_bad;
    logic [511:0] got_rd;
    logic         got_err;

    ysyx_220066_line_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .rd_req    (rd_req),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_error  (rd_error),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .wr_error  (wr_error),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    // Memory responder and recorder for one line request; cycle 0 is the cycle the request is raised.
    task automatic run_xfer(input logic do_wr, input logic do_rd, input logic [31:0] a,
                            input logic [511:0] wd, input logic stall, input int err_beat);
        bit done;
        bit in_beat;
        int bi;
        done = 0; in_beat = 0;
        beats = 0; rdy_cyc = -1; rd_pulses = 0; wr_pulses = 0; hold_bad = 0;
        got_err = 1'b0; got_rd = '0;
        addr = a; wr_data = wd; wr_req = do_wr; rd_req = do_rd;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
            mem_ready = stall ? (cyc % 2 == 0) : 1'b1;
            mem_err = 1'b0;
            if (mem_valid && beats < 16) begin
                if (in_beat) begin
                    if (mem_addr !== addr_log[beats] || mem_we !== we_log[beats] ||
                        mem_wdata !== wdata_log[beats])
                        hold_bad++;
                end else begin
                    addr_log[beats]  = mem_addr;
                    wdata_log[beats] = mem_wdata;
                    we_log[beats]    = mem_we;
                end
                bi = beats % 8;
                mem_rdata = rdata_tab[bi];
                mem_err = (beats == err_beat);
                if (mem_ready) begin
                    beats++;
                    in_beat = 0;
                end else begin
                    in_beat = 1;
                end
            end
            if (rd_ready) begin
                rd_pulses++; rdy_cyc = cyc; got_rd = rd_data; got_err = rd_error; done = 1;
            end
            if (wr_ready) begin
                wr_pulses++; rdy_cyc = cyc; got_err = wr_error; done = 1;
            end
        end
        @(posedge clk); #1;
        rd_req = 1'b0; wr_req = 1'b0; mem_err = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++;
        if (mem_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 64'h0)
            $display("FAIL reset_mem: got valid=%b we=%b addr=%h wdata=%h, expected all 0",
                     mem_valid, mem_we, mem_addr, mem_wdata);
        else pass_cnt++;
        total_cnt++;
        if (rd_ready !== 1'b0 || wr_ready !== 1'b0 || rd_error !== 1'b0 || wr_error !== 1'b0 || rd_data !== 512'h0)
            $display("FAIL reset_resp: got rd_ready=%b wr_ready=%b rd_err=%b wr_err=%b, expected 0",
                     rd_ready, wr_ready, rd_error, wr_error);
        else pass_cnt++;
        total_cnt++;
        if (mem_wstrb !== 8'hFF) $display("FAIL reset_wstrb: got %h expected ff", mem_wstrb);
        else pass_cnt++;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cached_read();
        for (int k = 0; k < 8; k++) rdata_tab[k] = 64'h1111_0000_0000_0000 | 64'(k);
        run_xfer(1'b0, 1'b1, 32'h8000_0040, '0, 1'b0, -1);
        total_cnt++;
        if (beats !== 8) $display("FAIL crd_beats: got %0d expected 8", beats); else pass_cnt++;
        total_cnt++;
        if (rdy_cyc !== 9) $display("FAIL crd_latency: got %0d expected 9", rdy_cyc); else pass_cnt++;
        total_cnt++;
        if (rd_pulses !== 1 || wr_pulses !== 0)
            $display("FAIL crd_pulses: got rd=%0d wr=%0d expected rd=1 wr=0", rd_pulses, wr_pulses);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            total_cnt++;
            if (addr_log[k] !== 32'h8000_0040 + 32'(8 * k) || we_log[k] !== 1'b0)
                $display("FAIL crd_addr[%0d]: got %h we=%b expected %h we=0",
                         k, addr_log[k], we_log[k], 32'h8000_0040 + 32'(8 * k));
            else pass_cnt++;
            total_cnt++;
            if (got_rd[64*k +: 64] !== (64'h1111_0000_0000_0000 | 64'(k)))
                $display("FAIL crd_data[%0d]: got %h expected %h", k, got_rd[64*k +: 64],
                         64'h1111_0000_0000_0000 | 64'(k));
            else pass_cnt++;
        end
        total_cnt++;
        if (got_err !== 1'b0) $display("FAIL crd_error: got %b expected 0", got_err); else pass_cnt++;
    endtask

    task automatic test_cached_write();
        logic [511:0] wd;
        for (int k = 0; k < 8; k++) wd[64*k +: 64] = 64'hA0 + 64'(k);
        run_xfer(1'b1, 1'b0, 32'h8000_1000, wd, 1'b1, -1);
        total_cnt++;
        if (beats !== 8) $display("FAIL cwr_beats: got %0d expected 8", beats); else pass_cnt++;
        total_cnt++;
        if (wr_pulses !== 1 || rd_pulses !== 0)
            $display("FAIL cwr_pulses: got wr=%0d rd=%0d expected wr=1 rd=0", wr_pulses, rd_pulses);
        else pass_cnt++;
        total_cnt++;
        if (rdy_cyc !== 17) $display("FAIL cwr_latency: got %0d expected 17", rdy_cyc); else pass_cnt++;
        total_cnt++;
        if (hold_bad !== 0) $display("FAIL cwr_hold: got %0d unstable cycles expected 0", hold_bad);
        else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            total_cnt++;
            if (addr_log[k] !== 32'h8000_1000 + 32'(8 * k) || we_log[k] !== 1'b1 ||
                wdata_log[k] !== 64'hA0 + 64'(k))
                $display("FAIL cwr_beat[%0d]: got addr=%h we=%b data=%h expected addr=%h we=1 data=%h",
                         k, addr_log[k], we_log[k], wdata_log[k], 32'h8000_1000 + 32'(8 * k), 64'hA0 + 64'(k));
            else pass_cnt++;
        end
        total_cnt++;
        if (mem_wstrb !== 8'hFF) $display("FAIL cwr_wstrb: got %h expected ff", mem_wstrb); else pass_cnt++;
        total_cnt++;
        if (got_err !== 1'b0) $display("FAIL cwr_error: got %b expected 0", got_err); else pass_cnt++;
    endtask

    task automatic test_uncached_read();
        for (int k = 0; k < 8; k++) rdata_tab[k] = 64'h5555_0000_0000_0000 | 64'(k);
        rdata_tab[0] = 64'hDEAD_BEEF;
        run_xfer(1'b0, 1'b1, 32'h1000_0000, '0, 1'b0, -1);
        total_cnt++;
        if (beats !== 1) $display("FAIL unc_beats: got %0d expected 1", beats); else pass_cnt++;
        total_cnt++;
        if (addr_log[0] !== 32'h1000_0000) $display("FAIL unc_addr: got %h expected 10000000", addr_log[0]);
        else pass_cnt++;
        total_cnt++;
        if (rdy_cyc !== 2) $display("FAIL unc_latency: got %0d expected 2", rdy_cyc); else pass_cnt++;
        total_cnt++;
        if (got_rd !== 512'hDEAD_BEEF) $display("FAIL unc_data: got hi=%h lo=%h expected hi=0 lo=deadbeef",
                                                 got_rd[511:64], got_rd[63:0]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [511:0] wd;
        int bad;
        int extra;
        for (int k = 0; k < 8; k++) wd[64*k +: 64] = 64'h2000 + 64'(k);
        run_xfer(1'b1, 1'b1, 32'h8000_2000, wd, 1'b0, -1);
        total_cnt++;
        if (wr_pulses !== 1 || rd_pulses !== 0 || beats !== 8)
            $display("FAIL b2b_wr_first: got wr=%0d rd=%0d beats=%0d expected 1 0 8", wr_pulses, rd_pulses, beats);
        else pass_cnt++;
        bad = 0;
        for (int k = 0; k < 8; k++)
            if (we_log[k] !== 1'b1 || addr_log[k] !== 32'h8000_2000 + 32'(8 * k) ||
                wdata_log[k] !== 64'h2000 + 64'(k)) bad++;
        total_cnt++;
        if (bad !== 0) $display("FAIL b2b_wr_beats: got %0d bad beats expected 0", bad); else pass_cnt++;
        for (int k = 0; k < 8; k++) rdata_tab[k] = 64'h3000_0000_0000_0000 + 64'(k);
        run_xfer(1'b0, 1'b1, 32'h8000_3000, '0, 1'b0, -1);
        total_cnt++;
        if (rd_pulses !== 1 || rdy_cyc !== 9 || beats !== 8)
            $display("FAIL b2b_rd: got pulses=%0d cyc=%0d beats=%0d expected 1 9 8", rd_pulses, rdy_cyc, beats);
        else pass_cnt++;
        bad = 0;
        for (int k = 0; k < 8; k++)
            if (we_log[k] !== 1'b0 || addr_log[k] !== 32'h8000_3000 + 32'(8 * k) ||
                got_rd[64*k +: 64] !== 64'h3000_0000_0000_0000 + 64'(k)) bad++;
        total_cnt++;
        if (bad !== 0) $display("FAIL b2b_rd_beats: got %0d bad beats expected 0", bad); else pass_cnt++;
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_valid || rd_ready || wr_ready) extra++;
            @(posedge clk); #1;
        end
        total_cnt++;
        if (extra !== 0) $display("FAIL b2b_no_third: got %0d active cycles expected 0", extra); else pass_cnt++;
    endtask

    task automatic test_error_read();
        for (int k = 0; k < 8; k++) rdata_tab[k] = 64'hE000 + 64'(k);
        run_xfer(1'b0, 1'b1, 32'h8000_0080, '0, 1'b0, 3);
        total_cnt++;
        if (beats !== 8 || rdy_cyc !== 9) $display("FAIL err_beats: got beats=%0d cyc=%0d expected 8 9", beats, rdy_cyc);
        else pass_cnt++;
        total_cnt++;
        if (got_err !== 1'b1) $display("FAIL err_flag: got %b expected 1", got_err); else pass_cnt++;
        total_cnt++;
        if (got_rd[255:192] !== 64'hE003) $display("FAIL err_data3: got %h expected e003", got_rd[255:192]);
        else pass_cnt++;
        run_xfer(1'b0, 1'b1, 32'h8000_00C0, '0, 1'b0, -1);
        total_cnt++;
        if (got_err !== 1'b0 || rd_pulses !== 1) $display("FAIL err_cleared: got err=%b pulses=%0d expected 0 1",
                                                          got_err, rd_pulses);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        logic [511:0] wd;
        int seen;
        for (int k = 0; k < 8; k++) wd[64*k +: 64] = 64'hB0 + 64'(k);
        addr = 32'h8000_1000; wr_data = wd; wr_req = 1'b1; mem_ready = 1'b1; mem_err = 1'b0;
        for (int cyc = 0; cyc <= 5; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h8000_1020 || mem_wdata !== 64'hB4)
            $display("FAIL rst_pre: got valid=%b addr=%h data=%h expected 1 80001020 b4", mem_valid, mem_addr, mem_wdata);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (mem_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 64'h0 ||
            wr_ready !== 1'b0 || rd_ready !== 1'b0 || rd_data !== 512'h0 || mem_wstrb !== 8'hFF)
            $display("FAIL rst_outputs: got valid=%b we=%b addr=%h wdata=%h wr_ready=%b expected zeros",
                     mem_valid, mem_we, mem_addr, mem_wdata, wr_ready);
        else pass_cnt++;
        wr_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (wr_ready || mem_valid) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL rst_quiet: got %0d active cycles expected 0", seen); else pass_cnt++;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) rdata_tab[k] = 64'h7700 + 64'(k);
        run_xfer(1'b0, 1'b1, 32'h8000_0000, '0, 1'b0, -1);
        total_cnt++;
        if (rd_pulses !== 1 || rdy_cyc !== 9 || beats !== 8 || got_err !== 1'b0)
            $display("FAIL rst_after_rd: got pulses=%0d cyc=%0d beats=%0d err=%b expected 1 9 8 0",
                     rd_pulses, rdy_cyc, beats, got_err);
        else pass_cnt++;
        total_cnt++;
        if (got_rd[63:0] !== 64'h7700 || got_rd[511:448] !== 64'h7707)
            $display("FAIL rst_after_data: got lo=%h hi=%h expected 7700 7707", got_rd[63:0], got_rd[511:448]);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_cached_read();
        test_cached_write();
        test_uncached_read();
        test_back_to_back();
        test_error_read();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
